// File: rtl/decode_scan.sv
// Switch-to-LED one-hot decoder with synchronised/debounced select,
// auto-scan running light, programmable scan rate/direction and output enable.
module decode_scan #(
  parameter int unsigned SEL_W      = 3,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned DEB_CYC    = 4,
  parameter int unsigned SCAN_DIV   = 12000000,
  localparam int unsigned OUT_W     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  output logic [OUT_W-1:0] code,
  output logic [SEL_W-1:0] idx,
  output logic             step
);

  localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]    DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [OUT_W-1:0] ALL_OFF  = {OUT_W{ACTIVE_LOW}};

  typedef enum logic {ST_STATIC, ST_SCAN} state_t;

  logic [SEL_W-1:0] sync1, sync2, cand, deb_sel;
  logic [DW-1:0]    deb_cnt;
  state_t           state, state_nxt;
  logic [PW-1:0]    presc, presc_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic             step_nxt;
  logic [OUT_W-1:0] code_nxt;

  // Index i lights bit OUT_W-1-i, which is simply bit ~i.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v     = '0;
    v[~i] = 1'b1;
    return ACTIVE_LOW ? ~v : v;
  endfunction

  // Two-flop synchroniser followed by a stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      cand    <= '0;
      deb_cnt <= '0;
      deb_sel <= '0;
    end else begin
      sync1 <= sel;
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand    <= sync2;
        deb_cnt <= '0;
      end else if (deb_cnt != DEB_LAST) begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (deb_cnt == DEB_LAST) begin
        deb_sel <= cand;
      end
    end
  end

  // Scan control: enable freezes everything; mode entry beats terminal count.
  always_comb begin
    state_nxt = state;
    presc_nxt = presc;
    idx_nxt   = idx;
    step_nxt  = 1'b0;
    code_nxt  = ALL_OFF;
    if (en) begin
      state_nxt = mode ? ST_SCAN : ST_STATIC;
      if (!mode || state == ST_STATIC) begin
        idx_nxt   = deb_sel;
        presc_nxt = '0;
      end else if (presc == PRE_LAST) begin
        presc_nxt = '0;
        idx_nxt   = dir ? idx - SEL_W'(1) : idx + SEL_W'(1);
        step_nxt  = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
      code_nxt = decode(idx_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_STATIC;
      presc <= '0;
      idx   <= '0;
      step  <= 1'b0;
      code  <= ALL_OFF;
    end else begin
      state <= state_nxt;
      presc <= presc_nxt;
      idx   <= idx_nxt;
      step  <= step_nxt;
      code  <= code_nxt;
    end
  end

endmodule

// File: tb/tb_decode_scan.sv
// Bench for decode_scan: scoreboard against a window-based behavioural model
// on an 8-LED scanning instance, plus directed checks on a 16-LED static instance.
module tb_decode_scan;

  localparam int DEB = 4;
  localparam int DIV = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, mode, dir;
  logic [2:0] sel;
  logic [7:0] code;
  logic [2:0] idx;
  logic       step;

  logic        rst2, en2, mode2, dir2;
  logic [3:0]  sel2;
  logic [15:0] code2;
  logic [3:0]  idx2;
  logic        step2;

  decode_scan #(.SEL_W(3), .ACTIVE_LOW(1'b1), .DEB_CYC(DEB), .SCAN_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .sel(sel), .en(en), .mode(mode), .dir(dir),
    .code(code), .idx(idx), .step(step)
  );

  decode_scan #(.SEL_W(4), .ACTIVE_LOW(1'b0), .DEB_CYC(1), .SCAN_DIV(3)) dut2 (
    .clk(clk), .rst(rst2), .sel(sel2), .en(en2), .mode(mode2), .dir(dir2),
    .code(code2), .idx(idx2), .step(step2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] code;
    logic [2:0] idx;
    logic       step;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Active-low LED pattern for index i: bit 7-i is the lit (zero) bit.
  function automatic logic [7:0] led(input int i);
    return ~(8'h80 >> i);
  endfunction

  // Reference model: sel is accepted once DEB consecutive synchronised samples agree.
  int m_hist[$];
  int m_deb, m_idx, m_presc;
  bit m_scan;

  task automatic model_edge();
    exp_t e;
    bit   same;
    int   nidx;
    if (rst) begin
      m_hist = {};
      repeat (DEB + 3) m_hist.push_back(0);
      m_deb = 0; m_idx = 0; m_presc = 0; m_scan = 1'b0;
      e.code = 8'hFF; e.idx = 3'd0; e.step = 1'b0;
    end else begin
      e.step = 1'b0;
      nidx   = m_idx;
      if (en) begin
        if (!mode || !m_scan) begin
          nidx    = m_deb;
          m_presc = 0;
        end else if (m_presc == DIV - 1) begin
          m_presc = 0;
          nidx    = dir ? (m_idx + 7) % 8 : (m_idx + 1) % 8;
          e.step  = 1'b1;
        end else begin
          m_presc++;
        end
        m_scan = mode;
      end
      m_idx  = nidx;
      e.idx  = 3'(m_idx);
      e.code = en ? led(m_idx) : 8'hFF;
      m_hist.push_back(int'(sel));
      if (m_hist.size() > DEB + 3) void'(m_hist.pop_front());
      same = 1'b1;
      for (int i = 1; i < DEB; i++) if (m_hist[i] != m_hist[0]) same = 1'b0;
      if (same) m_deb = m_hist[0];
    end
    exp_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Monitor: every registered output update is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: no expected entry at t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        chk("sb_code", 32'(code), 32'(e.code));
        chk("sb_idx",  32'(idx),  32'(e.idx));
        chk("sb_step", 32'(step), 32'(e.step));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[6] = '{9, 0, 15, 5, 12, 3};
    int prev;
    rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0; sel = 3'b101;
    rst2 = 1'b1; en2 = 1'b1; mode2 = 1'b0; dir2 = 1'b0; sel2 = 4'd0;

    // Reset and power-up latency
    cyc(2);
    chk("reset_code", 32'(code), 32'h0FF);
    rst = 1'b0;
    cyc(1);
    chk("first_edge_code", 32'(code), 32'h07F);
    cyc(7);
    chk("edge8_code", 32'(code), 32'h0FB);

    // Glitch rejection then accepted hold
    sel = 3'b000; cyc(12);
    chk("glitch_pre", 32'(code), 32'h07F);
    sel = 3'b010; cyc(3);
    sel = 3'b000; cyc(12);
    chk("glitch_post", 32'(code), 32'h07F);
    sel = 3'b010; cyc(8);
    chk("hold_accept", 32'(code), 32'h0DF);

    // Scan up with wrap
    sel = 3'b110; cyc(10);
    mode = 1'b1; dir = 1'b0; cyc(1);
    chk("scan_entry_idx", 32'(idx), 32'd6);
    chk("scan_entry_code", 32'(code), 32'h0FD);
    cyc(5);
    chk("scan_up_idx7", 32'(idx), 32'd7);
    chk("scan_up_step", 32'(step), 32'd1);
    cyc(1);
    chk("scan_step_low", 32'(step), 32'd0);
    cyc(4);
    chk("scan_wrap_code", 32'(code), 32'h07F);

    // Scan down with wrap
    mode = 1'b0; sel = 3'b000; cyc(10);
    mode = 1'b1; dir = 1'b1; cyc(6);
    chk("scan_down_idx7", 32'(idx), 32'd7);
    chk("scan_down_code7", 32'(code), 32'h0FE);
    cyc(5);
    chk("scan_down_code6", 32'(code), 32'h0FD);

    // Enable freeze/resume and reset mid-scan
    mode = 1'b0; dir = 1'b0; sel = 3'b011; cyc(10);
    mode = 1'b1; cyc(3);
    en = 1'b0; cyc(1);
    chk("en_off_code", 32'(code), 32'h0FF);
    chk("en_off_step", 32'(step), 32'd0);
    cyc(2);
    en = 1'b1; cyc(1);
    chk("en_on_code", 32'(code), 32'h0EF);
    cyc(1);
    chk("en_on_idx_hold", 32'(idx), 32'd3);
    cyc(1);
    chk("en_resume_idx", 32'(idx), 32'd4);
    chk("en_resume_step", 32'(step), 32'd1);
    cyc(2);
    rst = 1'b1; cyc(1);
    chk("rst_mid_code", 32'(code), 32'h0FF);
    chk("rst_mid_idx", 32'(idx), 32'd0);
    rst = 1'b0;

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) sel = 3'($urandom);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 19) == 0) dir = ~dir;
      rst = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;

    // 16-LED active-high instance, single-sample debounce
    rst2 = 1'b0; cyc(6);
    chk("g_reset_code", 32'(code2), 32'h8000);
    prev = 0;
    foreach (vals[k]) begin
      sel2 = 4'(vals[k]);
      cyc(4);
      chk("g_edge4_code", 32'(code2), 32'(16'h8000 >> prev));
      cyc(1);
      chk("g_edge5_code", 32'(code2), 32'(16'h8000 >> vals[k]));
      chk("g_edge5_idx", 32'(idx2), 32'(vals[k]));
      chk("g_step", 32'(step2), 32'd0);
      prev = vals[k];
    end
    en2 = 1'b0; cyc(1);
    chk("g_en_off", 32'(code2), 32'h0000);
    en2 = 1'b1; cyc(1);
    chk("g_en_on", 32'(code2), 32'(16'h8000 >> prev));

    cyc(1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
